// File: rtl/sprite_pos_regs.sv
// Sprite position register bank: the CPU writes shadow registers and the live
// positions seen by bit_gen are copied from them only at an armed vsync start.
module sprite_pos_regs #(
  parameter int   CORDW        = 16,
  parameter logic VSYNC_ACTIVE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic             we,
  input  logic [2:0]       addr,
  input  logic [CORDW-1:0] wdata,
  output logic [CORDW-1:0] rdata,
  output logic [CORDW-1:0] mx,
  output logic [CORDW-1:0] my,
  output logic [CORDW-1:0] p1x,
  output logic [CORDW-1:0] p1y,
  output logic [CORDW-1:0] p2x,
  output logic [CORDW-1:0] p2y,
  output logic             commit,
  output logic             frame_tick
);

  // CPU port: a write is taken on every cycle with we=1; there is no ready,
  // and rdata always shows the register addressed one cycle earlier.

  typedef enum logic {S_IDLE = 1'b0, S_ARMED = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [5:0][CORDW-1:0]   shadow_q, shadow_d;
  logic [5:0][CORDW-1:0]   live_q, live_d;
  logic [CORDW-1:0]        rdata_q, rdata_d;
  logic [CORDW-2:0]        frame_cnt_q, frame_cnt_d;
  logic                    vsync_dly_q, vsync_dly_d;
  logic                    commit_q, commit_d;
  logic                    frame_tick_q, frame_tick_d;
  logic                    vs_edge;
  logic                    arm_wr;
  logic                    pending;

  always_comb begin
    vs_edge = (vsync == VSYNC_ACTIVE) && (vsync_dly_q != VSYNC_ACTIVE);
    arm_wr  = we && (addr == 3'd7) && wdata[0];
  end

  // Controller: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Controller: next state; an arm in the edge cycle while idle waits a frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arm_wr)  state_d = S_ARMED;
      S_ARMED: if (vs_edge) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Controller: outputs
  always_comb begin
    pending  = (state_q == S_ARMED);
    commit_d = pending && vs_edge;
  end

  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < 6; i++) begin
      if (we && (addr == 3'(i))) shadow_d[i] = wdata;
    end
    // Copy the pre-write shadows so a same-cycle CPU write lands next frame
    live_d       = commit_d ? shadow_q : live_q;
    frame_cnt_d  = frame_cnt_q + {{(CORDW-2){1'b0}}, vs_edge};
    frame_tick_d = vs_edge;
    vsync_dly_d  = vsync;
    case (addr)
      3'd0:    rdata_d = shadow_q[0];
      3'd1:    rdata_d = shadow_q[1];
      3'd2:    rdata_d = shadow_q[2];
      3'd3:    rdata_d = shadow_q[3];
      3'd4:    rdata_d = shadow_q[4];
      3'd5:    rdata_d = shadow_q[5];
      3'd6:    rdata_d = {frame_cnt_q, pending};
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q     <= '0;
      live_q       <= '0;
      rdata_q      <= '0;
      frame_cnt_q  <= '0;
      vsync_dly_q  <= VSYNC_ACTIVE;
      commit_q     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      live_q       <= live_d;
      rdata_q      <= rdata_d;
      frame_cnt_q  <= frame_cnt_d;
      vsync_dly_q  <= vsync_dly_d;
      commit_q     <= commit_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign rdata      = rdata_q;
  assign mx         = live_q[0];
  assign my         = live_q[1];
  assign p1x        = live_q[2];
  assign p1y        = live_q[3];
  assign p2x        = live_q[4];
  assign p2y        = live_q[5];
  assign commit     = commit_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sprite_pos_regs.sv
// Bench for sprite_pos_regs: directed scenarios with literal expectations and
// a per-cycle comparison against a frame-level model of the register bank.
module tb_sprite_pos_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [15:0] wdata = 16'd0;
  logic [15:0] rdata, mx, my, p1x, p1y, p2x, p2y;
  logic        commit, frame_tick;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  sprite_pos_regs #(.CORDW(16), .VSYNC_ACTIVE(1'b0)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .mx(mx), .my(my), .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y),
    .commit(commit), .frame_tick(frame_tick)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // model: shadows, live copy, arm flag and frame count kept as plain values
  logic [15:0] m_shadow [6];
  logic [15:0] m_live   [6];
  logic [15:0] m_rdata;
  bit          m_pending, m_commit, m_tick, m_prev_vs;
  int          m_frames;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin m_shadow[i] = 16'd0; m_live[i] = 16'd0; end
      m_rdata = 16'd0; m_pending = 0; m_commit = 0; m_tick = 0;
      m_frames = 0; m_prev_vs = 0;
    end else begin
      automatic bit start = (vsync == 1'b0) && m_prev_vs;
      if (addr < 3'd6)       m_rdata = m_shadow[addr];
      else if (addr == 3'd6) m_rdata = 16'((m_frames % 32768) * 2 + (m_pending ? 1 : 0));
      else                   m_rdata = 16'd0;
      m_tick   = start;
      m_commit = start && m_pending;
      if (m_commit) for (int i = 0; i < 6; i++) m_live[i] = m_shadow[i];
      if (m_commit) m_pending = 0;
      else if (we && addr == 3'd7 && wdata[0]) m_pending = 1;
      if (we && addr < 3'd6) m_shadow[addr] = wdata;
      if (start) m_frames = (m_frames + 1) % 32768;
      m_prev_vs = vsync;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
  endtask

  // compare process, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_rdata", rdata, m_rdata);
      check("cmp_mx", mx, m_live[0]);
      check("cmp_my", my, m_live[1]);
      check("cmp_p1x", p1x, m_live[2]);
      check("cmp_p1y", p1y, m_live[3]);
      check("cmp_p2x", p2x, m_live[4]);
      check("cmp_p2y", p2y, m_live[5]);
      check("cmp_commit", 16'(commit), 16'(m_commit));
      check("cmp_tick", 16'(frame_tick), 16'(m_tick));
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0; wdata = 16'd0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    addr = a;
    tick();
    d = rdata;
  endtask

  task automatic frame();
    vsync = 1'b1; tick();
    vsync = 1'b0; tick();
  endtask

  task automatic mid_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_rdata"}, rdata, 16'd0);
    check({tag, "_live"}, mx | my | p1x | p1y | p2x | p2y, 16'd0);
    check({tag, "_pulses"}, 16'({commit, frame_tick}), 16'd0);
    tick(); tick();
    rst = 1'b0;
  endtask

  logic [15:0] r;

  initial begin
    tick(); tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    // reset behaviour with nonzero state present
    wr(3'd0, 16'h1234);
    rd(3'd0, r);
    check("pre_reset_rd", r, 16'h1234);
    frame();
    mid_reset("rst1");
    tick(); tick();
    check("no_tick_after_release", 16'(frame_tick), 16'd0);
    vsync = 1'b1; tick();
    vsync = 1'b0; tick();
    check("tick_high", 16'(frame_tick), 16'd1);
    tick();
    check("tick_one_cycle", 16'(frame_tick), 16'd0);

    // shadow isolation, starting from a clean frame count
    mid_reset("rst2");
    wr(3'd0, 16'h0140);
    wr(3'd1, 16'h00F0);
    frame(); frame();
    check("iso_mx", mx, 16'd0);
    check("iso_my", my, 16'd0);
    rd(3'd0, r); check("iso_rd_mx", r, 16'h0140);
    rd(3'd6, r); check("iso_status", r, 16'h0004);
    wr(3'd6, 16'hFFFF);
    rd(3'd6, r); check("status_ro", r, 16'h0004);
    wr(3'd7, 16'h0002);
    rd(3'd7, r); check("ctrl_noarm", r, 16'h0000);
    rd(3'd6, r); check("ctrl_noarm_st", r, 16'h0004);

    // armed commit
    for (int i = 0; i < 6; i++) wr(3'(i), 16'((i + 1) * 16));
    wr(3'd7, 16'h0001);
    rd(3'd6, r); check("armed_status", r, 16'h0005);
    vsync = 1'b1; tick();
    vsync = 1'b0;
    check("before_edge_mx", mx, 16'h0140 & 16'h0000);
    tick();
    check("commit_pulse", 16'(commit), 16'd1);
    check("c_mx", mx, 16'h0010);
    check("c_my", my, 16'h0020);
    check("c_p1x", p1x, 16'h0030);
    check("c_p1y", p1y, 16'h0040);
    check("c_p2x", p2x, 16'h0050);
    check("c_p2y", p2y, 16'h0060);
    tick();
    check("commit_once", 16'(commit), 16'd0);
    addr = 3'd6; tick(); check("after_commit_st", rdata, 16'h0006);

    // arm coincident with edge
    wr(3'd0, 16'h0077);
    vsync = 1'b1; tick();
    vsync = 1'b0; we = 1'b1; addr = 3'd7; wdata = 16'h0001;
    tick();
    we = 1'b0; wdata = 16'd0;
    check("arm_edge_nocommit", 16'(commit), 16'd0);
    check("arm_edge_mx", mx, 16'h0010);
    rd(3'd6, r); check("arm_edge_status", r, 16'h0009);
    frame();
    check("arm_next_commit", 16'(commit), 16'd1);
    check("arm_next_mx", mx, 16'h0077);

    // shadow write coincident with commit
    wr(3'd2, 16'h000A);
    wr(3'd7, 16'h0001);
    vsync = 1'b1; tick();
    vsync = 1'b0; we = 1'b1; addr = 3'd2; wdata = 16'h000B;
    tick();
    we = 1'b0; wdata = 16'd0;
    check("cw_commit", 16'(commit), 16'd1);
    check("cw_live_p1x", p1x, 16'h000A);
    rd(3'd2, r); check("cw_shadow_p1x", r, 16'h000B);
    rd(3'd6, r); check("cw_status", r, 16'h000C);

    // frame counter wrap from a clean count
    mid_reset("rst3");
    for (int i = 0; i < 32767; i++) frame();
    rd(3'd6, r); check("cnt_max", r, 16'hFFFE);
    frame();
    rd(3'd6, r); check("cnt_wrap", r, 16'h0000);

    // reset aborts an armed commit
    wr(3'd3, 16'h0099);
    wr(3'd7, 16'h0001);
    mid_reset("rst4");
    frame();
    check("abort_commit", 16'(commit), 16'd0);
    check("abort_p1y", p1y, 16'd0);
    rd(3'd3, r); check("abort_shadow", r, 16'd0);
    rd(3'd6, r); check("abort_status", r, 16'h0002);
    tick();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_pos_regs.md
# sprite_pos_regs

Processor-facing register bank that holds the sprite screen positions consumed by `bit_gen` (`mx`, `my`, `p1x`, `p1y`, `p2x`, `p2y`). The CPU writes new positions into shadow registers at any time. The live outputs change only at the start of a vertical sync pulse, and only when a commit is armed, so a frame is never drawn with a half-updated sprite set. The block runs on the VGA pixel clock (`clk_25MHz`) and also provides a frame counter for software pacing.

## Interface
Parameters:
- `CORDW`, 16, coordinate and data width.
- `VSYNC_ACTIVE`, 1'b0, active level of `vsync` (640x480 sync is active-low).

Ports:
- `clk`  in  1  pixel clock (`clk_25MHz`).
- `rst`  in  1  reset; asynchronous, active-high.
- `vsync`  in  1  registered vertical sync (`vga_vsync`), same clock domain.
- `we`  in  1  CPU write strobe, one write per asserted cycle.
- `addr`  in  3  register select.
- `wdata`  in  CORDW  write data.
- `rdata`  out  CORDW  registered read data.
- `mx`, `my`, `p1x`, `p1y`, `p2x`, `p2y`  out  CORDW each  live positions to `bit_gen`.
- `commit`  out  1  one-cycle pulse when shadows are copied to the live outputs.
- `frame_tick`  out  1  one-cycle pulse on every vsync active edge.

## Operation
- Register map:
  - 0 = `mx` shadow
  - 1 = `my` shadow
  - 2 = `p1x` shadow
  - 3 = `p1y` shadow
  - 4 = `p2x` shadow
  - 5 = `p2y` shadow
  - 6 = STATUS (read-only): `{frame_cnt[CORDW-2:0], pending}`
  - 7 = CONTROL: write with `wdata[0]=1` arms a commit; reads return 0.
- Writes to addresses 0-5 update only the shadow register. The live outputs are unaffected until a commit.
- Writes to address 6 are ignored. Writes to address 7 with `wdata[0]=0` are ignored.
- Two-state controller:
  - IDLE: `pending=0`. A CONTROL arm write moves to ARMED.
  - ARMED: `pending=1`. Further arm writes have no effect. On a vsync edge, all six shadows are copied to the live registers in one cycle, `commit` pulses, and the controller returns to IDLE.
- Vsync edge detect: edge = (`vsync==VSYNC_ACTIVE`) && (`vsync_d!=VSYNC_ACTIVE`), where `vsync_d` is `vsync` delayed one clock.
- `frame_cnt` (CORDW-1 bits) increments on every edge, armed or not, and wraps from all-ones to 0.
- Simultaneous events:
  - Arm write in the same cycle as an edge: no commit this frame. The controller goes to ARMED and commits on the next edge.
  - Shadow write in the same cycle as a committing edge: the live output takes the pre-write shadow value. The new value stays in the shadow and `pending` ends at 0.
  - Reads in the same cycle as a write or commit return pre-update values.
- Reset mid-operation: all state is cleared immediately and any armed commit is discarded.
- Reset values:
  - shadows, live outputs, `rdata`, `frame_cnt` = 0
  - `pending` = 0, `commit` = 0, `frame_tick` = 0
  - `vsync_d` = `VSYNC_ACTIVE`, so that a vsync already active at reset release does not produce an edge.

## Timing
- Read latency is 1 cycle: `rdata` at cycle N+1 reflects `addr` at cycle N. `rdata` updates every cycle; there is no read strobe.
- Write latency is 1 cycle: the shadow holds the new value from cycle N+1.
- Edge to output: with `vsync` reaching its active level at cycle N, `vsync_d` is still inactive at N. The live outputs, `commit`, `frame_tick` and `frame_cnt` therefore all update at the clock edge ending cycle N and are visible in cycle N+1.
- The live outputs are stable for the whole active display region, because commits happen only at vsync start, which lies in vertical blanking.
- There is no back-pressure. The CPU may write every cycle.

## Test plan
- Reset behaviour:
  - Stimulus: assert `rst` mid-cycle with `vsync` held at 0.
  - Required response: all outputs 0 asynchronously.
  - Stimulus: release `rst` while `vsync=0`.
  - Required response: no `frame_tick`.
  - Stimulus: toggle `vsync` 1->0.
  - Required response: `frame_tick` high for exactly 1 cycle.
- Shadow isolation:
  - Stimulus: write `mx=0x0140` and `my=0x00F0`, then run 2 frames without arming.
  - Required response: `mx`/`my` stay 0; reading addr 0 returns 0x0140 one cycle later; STATUS bit0 = 0; `frame_cnt` = 2.
- Armed commit:
  - Stimulus: write all six shadows (0x10, 0x20, 0x30, 0x40, 0x50, 0x60), then write CONTROL=1.
  - Required response: STATUS bit0 = 1. On the next vsync falling edge, all six outputs change in the same cycle and `commit` pulses once. STATUS bit0 then reads 0.
- Arm coincident with edge:
  - Stimulus: CONTROL=1 written in the edge cycle.
  - Required response: no commit on that edge; commit occurs on the following edge.
- Shadow write coincident with commit:
  - Stimulus: `p1x` shadow = 0x0A, armed; write 0x0B to addr 2 in the edge cycle.
  - Required response: live `p1x` = 0x0A; addr 2 reads 0x0B; `pending` = 0.
- Counter wrap and reset abort:
  - Stimulus: run 2^15 edges.
  - Required response: `frame_cnt` returns to 0.
  - Stimulus: arm, then assert `rst` before the next edge.
  - Required response: no commit after reset release; outputs stay 0.
